// File: rtl/store_commit_buffer_if.sv
// store_commit_buffer_if: LSB allocate, ROB commit, byte-wide memory port and load-lookup signals.
interface store_commit_buffer_if #(
    parameter int LW = 5,
    parameter int AW = 32,
    parameter int VW = 32
);
    logic          rdy_in;
    logic          flush_in;
    logic          alloc_en;
    logic [LW-1:0] alloc_lab;
    logic [AW-1:0] alloc_addr;
    logic [VW-1:0] alloc_data;
    logic [1:0]    alloc_size;
    logic          rob2lsb_store_en;
    logic [LW-1:0] store_index;
    logic          mem_busy;
    logic          sb_full;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout;
    logic          mem_wr;
    logic          mem_gnt;
    logic [AW-1:0] ld_addr;
    logic          ld_stall;
    logic          ld_hit;
    logic [VW-1:0] ld_data;
    logic          sb_err;
    logic [31:0]   store_cnt;
    modport slave (
        input  rdy_in, flush_in, alloc_en, alloc_lab, alloc_addr, alloc_data, alloc_size,
               rob2lsb_store_en, store_index, mem_gnt, ld_addr,
        output mem_busy, sb_full, mem_req, mem_addr, mem_dout, mem_wr, ld_stall, ld_hit, ld_data,
               sb_err, store_cnt
    );
    modport master (
        output rdy_in, flush_in, alloc_en, alloc_lab, alloc_addr, alloc_data, alloc_size,
               rob2lsb_store_en, store_index, mem_gnt, ld_addr,
        input  mem_busy, sb_full, mem_req, mem_addr, mem_dout, mem_wr, ld_stall, ld_hit, ld_data,
               sb_err, store_cnt
    );
endinterface

// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order store buffer, ROB-committed stores drain byte-serially to memory.
// Define SB_FWD_EN to forward whole aligned committed words to loads instead of stalling them.
module store_commit_buffer #(
    parameter int SB_DEPTH     = 8,
    parameter int ROB_ID_WIDTH = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int VAL_WIDTH    = 32
) (
    input logic                  clk,
    input logic                  rst_in,
    store_commit_buffer_if.slave sb
);
    localparam int IW = $clog2(SB_DEPTH);
    localparam int LW = ROB_ID_WIDTH + 1;
    typedef enum logic {IDLE, WRITE} state_t;
    state_t                state_q, state_d;
    logic [IW:0]           head_q, head_d, cmt_q, cmt_d, tail_q, tail_d, cnt;
    logic [LW-1:0]         lab_q  [SB_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [SB_DEPTH];
    logic [VAL_WIDTH-1:0]  data_q [SB_DEPTH];
    logic [1:0]            size_q [SB_DEPTH];
    logic [1:0]            idx_q, idx_d, last_q, last_d;
    logic                  err_q, err_d;
    logic [31:0]           scnt_q, scnt_d;
    logic [IW-1:0]         hi, ci, ti, e;
    logic                  full, busy, commit, alloc, grant, done, match;
`ifdef SB_FWD_EN
    logic                  fwd;
    logic [VAL_WIDTH-1:0]  fdata;
`endif
    assign hi     = head_q[IW-1:0];
    assign ci     = cmt_q[IW-1:0];
    assign ti     = tail_q[IW-1:0];
    assign cnt    = tail_q - head_q;
    assign full   = cnt == (IW+1)'(SB_DEPTH);
    assign busy   = cmt_q == tail_q;
    assign commit = sb.rdy_in && sb.rob2lsb_store_en && !busy;
    assign alloc  = sb.rdy_in && sb.alloc_en && !full && !sb.flush_in;
    assign grant  = sb.rdy_in && state_q == WRITE && sb.mem_gnt;
    assign done   = grant && idx_q == last_q;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        head_d  = done ? head_q + 1'b1 : head_q;
        scnt_d  = done ? scnt_q + 32'd1 : scnt_q;
        cmt_d   = commit ? cmt_q + 1'b1 : cmt_q;
        // flush keeps a same-cycle commit: speculative region collapses onto the new cmt
        tail_d  = (sb.rdy_in && sb.flush_in) ? cmt_d : alloc ? tail_q + 1'b1 : tail_q;
        err_d   = err_q | (sb.rdy_in && sb.rob2lsb_store_en && (busy || lab_q[ci] != sb.store_index));
        if (sb.rdy_in && state_q == IDLE && cmt_q != head_q) begin
            state_d = WRITE;
            idx_d   = 2'd0;
            last_d  = size_q[hi] == 2'd0 ? 2'd0 : size_q[hi] == 2'd1 ? 2'd1 : 2'd3;
        end else if (grant) begin
            state_d = done ? IDLE : WRITE;
            idx_d   = idx_q + 2'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
        end
    end
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                lab_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else if (alloc) begin
            lab_q[ti]  <= sb.alloc_lab;
            addr_q[ti] <= sb.alloc_addr;
            data_q[ti] <= sb.alloc_data;
            size_q[ti] <= sb.alloc_size;
        end
    end
    assign sb.mem_busy  = busy;
    assign sb.sb_full   = full;
    assign sb.mem_req   = sb.rdy_in && state_q == WRITE;
    assign sb.mem_wr    = sb.mem_req;
    assign sb.mem_addr  = state_q == WRITE ? addr_q[hi] + ADDR_WIDTH'(idx_q) : '0;
    assign sb.mem_dout  = state_q == WRITE ? data_q[hi][8*idx_q +: 8] : '0;
    assign sb.sb_err    = err_q;
    assign sb.store_cnt = scnt_q;
    // scan committed entries oldest to youngest so the youngest match wins
    always_comb begin
        match = 1'b0;
        e     = '0;
`ifdef SB_FWD_EN
        fwd   = 1'b0;
        fdata = '0;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            e = hi + IW'(i);
            if ((IW+1)'(i) < cmt_q - head_q && addr_q[e][ADDR_WIDTH-1:2] == sb.ld_addr[ADDR_WIDTH-1:2]) begin
                match = 1'b1;
`ifdef SB_FWD_EN
                fwd   = size_q[e][1] && addr_q[e][1:0] == 2'b00 && !(i == 0 && state_q == WRITE);
                fdata = data_q[e];
`endif
            end
        end
    end
`ifdef SB_FWD_EN
    assign sb.ld_hit   = match && fwd;
    assign sb.ld_data  = (match && fwd) ? fdata : '0;
    assign sb.ld_stall = match && !fwd;
`else
    assign sb.ld_hit   = 1'b0;
    assign sb.ld_data  = '0;
    assign sb.ld_stall = match;
`endif
endmodule

// File: tb/tb_store_commit_buffer.sv
// tb_store_commit_buffer: directed stimulus checked every cycle against a queue-based store buffer model.
module tb_store_commit_buffer;
    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;
    store_commit_buffer_if sb ();
    store_commit_buffer dut (.clk(clk), .rst_in(rst_in), .sb(sb));
    typedef struct packed {logic [4:0] lab; logic [31:0] addr; logic [31:0] data; logic [1:0] size;} ent_t;
    ent_t        m_q[$];
    int          ncmt, pos, cnt, vecs, fails;
    bit          active, err;
    logic [31:0] log_a[$];
    logic [7:0]  log_d[$];
    function automatic int nbytes(logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic mreset();
        m_q.delete();
        ncmt = 0; pos = 0; cnt = 0; active = 0; err = 0;
    endtask
    task automatic check_model();
        logic [31:0] ea, ed, fd;
        bit m, ok;
        ea = active ? m_q[0].addr + 32'(pos) : 32'd0;
        ed = active ? (m_q[0].data >> (8 * pos)) & 32'hff : 32'd0;
        m = 0; ok = 0; fd = 0;
        for (int i = 0; i < ncmt; i++)
            if (m_q[i].addr[31:2] == sb.ld_addr[31:2]) begin
                m  = 1;
                ok = m_q[i].size >= 2 && m_q[i].addr[1:0] == 2'b00 && !(i == 0 && active);
                fd = m_q[i].data;
            end
        chk("mem_busy", 32'(sb.mem_busy), 32'(ncmt == m_q.size()));
        chk("sb_full", 32'(sb.sb_full), 32'(m_q.size() == 8));
        chk("mem_req", 32'(sb.mem_req), 32'(active && sb.rdy_in));
        chk("mem_wr", 32'(sb.mem_wr), 32'(active && sb.rdy_in));
        chk("mem_addr", sb.mem_addr, ea);
        chk("mem_dout", 32'(sb.mem_dout), ed);
        chk("sb_err", 32'(sb.sb_err), 32'(err));
        chk("store_cnt", sb.store_cnt, 32'(cnt));
`ifdef SB_FWD_EN
        chk("ld_hit", 32'(sb.ld_hit), 32'(m && ok));
        chk("ld_stall", 32'(sb.ld_stall), 32'(m && !ok));
        chk("ld_data", sb.ld_data, (m && ok) ? fd : 32'd0);
`else
        chk("ld_hit", 32'(sb.ld_hit), 32'd0);
        chk("ld_stall", 32'(sb.ld_stall), 32'(m));
        chk("ld_data", sb.ld_data, 32'd0);
`endif
    endtask
    task automatic step_model();
        bit full_o, busy_o, start;
        if (!rst_in || !sb.rdy_in) return;
        full_o = m_q.size() == 8;
        busy_o = ncmt == m_q.size();
        start  = !active && ncmt > 0;
        if (sb.rob2lsb_store_en) begin
            if (busy_o) err = 1;
            else begin
                if (m_q[ncmt].lab != sb.store_index) err = 1;
                ncmt++;
            end
        end
        if (sb.flush_in) begin
            while (m_q.size() > ncmt) void'(m_q.pop_back());
        end else if (sb.alloc_en && !full_o)
            m_q.push_back('{sb.alloc_lab, sb.alloc_addr, sb.alloc_data, sb.alloc_size});
        if (active && sb.mem_gnt) begin
            pos++;
            if (pos == nbytes(m_q[0].size)) begin
                void'(m_q.pop_front());
                ncmt--; cnt++; active = 0;
            end
        end else if (start) begin
            active = 1; pos = 0;
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        check_model();
        if (sb.mem_req && sb.mem_gnt) begin
            log_a.push_back(sb.mem_addr);
            log_d.push_back(sb.mem_dout);
        end
        step_model();
        @(posedge clk);
        #1;
    endtask
    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask
    task automatic alloc(logic [4:0] lab, logic [31:0] a, logic [31:0] d, logic [1:0] s);
        sb.alloc_en = 1; sb.alloc_lab = lab; sb.alloc_addr = a; sb.alloc_data = d; sb.alloc_size = s;
        cyc();
        sb.alloc_en = 0;
    endtask
    task automatic commit(logic [4:0] idx);
        sb.rob2lsb_store_en = 1; sb.store_index = idx;
        cyc();
        sb.rob2lsb_store_en = 0;
    endtask
    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] exp1[4];
        exp1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        vecs = 0; fails = 0;
        sb.rdy_in = 1; sb.flush_in = 0; sb.alloc_en = 0; sb.alloc_lab = 0; sb.alloc_addr = 0;
        sb.alloc_data = 0; sb.alloc_size = 0; sb.rob2lsb_store_en = 0; sb.store_index = 0;
        sb.mem_gnt = 0; sb.ld_addr = 32'hFFFF_0000;
        rst_in = 0;
        mreset();
        run(2);
        chk("rst_mem_busy", 32'(sb.mem_busy), 32'd1);
        chk("rst_mem_req", 32'(sb.mem_req), 32'd0);
        chk("rst_sb_full", 32'(sb.sb_full), 32'd0);
        rst_in = 1;
        run(1);
        // word store drains little-endian
        sb.mem_gnt = 1;
        clear_log();
        alloc(5'd3, 32'h1000, 32'hA1B2C3D4, 2'd2);
        commit(5'd3);
        run(8);
        chk("t1_nbytes", 32'(log_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", log_a[i], 32'h1000 + 32'(i));
            chk("t1_data", 32'(log_d[i]), 32'(exp1[i]));
        end
        chk("t1_store_cnt", sb.store_cnt, 32'd1);
        // byte and half stores
        clear_log();
        alloc(5'd5, 32'h2003, 32'h55, 2'd0);
        commit(5'd5);
        alloc(5'd6, 32'h2000, 32'hBEEF, 2'd1);
        commit(5'd6);
        run(10);
        chk("t2_nbytes", 32'(log_a.size()), 32'd3);
        chk("t2_a0", log_a[0], 32'h2003);
        chk("t2_d0", 32'(log_d[0]), 32'h55);
        chk("t2_a1", log_a[1], 32'h2000);
        chk("t2_d1", 32'(log_d[1]), 32'hEF);
        chk("t2_a2", log_a[2], 32'h2001);
        chk("t2_d2", 32'(log_d[2]), 32'hBE);
        // flush drops speculative stores and a same-cycle alloc
        sb.mem_gnt = 0;
        alloc(5'd1, 32'h4000, 32'h77, 2'd0);
        alloc(5'd2, 32'h4004, 32'h88, 2'd0);
        alloc(5'd3, 32'h4008, 32'h99, 2'd0);
        commit(5'd1);
        sb.flush_in = 1;
        alloc(5'd4, 32'h400C, 32'hAA, 2'd0);
        sb.flush_in = 0;
        chk("t3_busy", 32'(sb.mem_busy), 32'd1);
        clear_log();
        sb.mem_gnt = 1;
        run(6);
        chk("t3_nbytes", 32'(log_a.size()), 32'd1);
        chk("t3_addr", log_a[0], 32'h4000);
        chk("t3_data", 32'(log_d[0]), 32'h77);
        // full buffer, ignored ninth alloc, freed slot reused
        sb.mem_gnt = 0;
        for (int i = 1; i <= 8; i++) alloc(5'(i), 32'h5000 + 32'(i), 32'(i), 2'd0);
        chk("t4_full", 32'(sb.sb_full), 32'd1);
        alloc(5'd9, 32'h5FFF, 32'hEE, 2'd0);
        chk("t4_full_hold", 32'(sb.sb_full), 32'd1);
        commit(5'd1);
        run(1);
        sb.mem_gnt = 1;
        run(1);
        sb.mem_gnt = 0;
        chk("t4_not_full", 32'(sb.sb_full), 32'd0);
        alloc(5'd9, 32'h5009, 32'h09, 2'd0);
        chk("t4_full_again", 32'(sb.sb_full), 32'd1);
        sb.mem_gnt = 1;
        for (int i = 2; i <= 9; i++) commit(5'(i));
        run(20);
        chk("t4_store_cnt", sb.store_cnt, 32'd13);
        // label mismatch, then grant held low mid-word
        alloc(5'd4, 32'h6000, 32'hCAFEF00D, 2'd2);
        commit(5'd7);
        chk("t5_err", 32'(sb.sb_err), 32'd1);
        run(2);
        sb.mem_gnt = 0;
        chk("t5_req", 32'(sb.mem_req), 32'd1);
        chk("t5_addr", sb.mem_addr, 32'h6001);
        chk("t5_dout", 32'(sb.mem_dout), 32'hF0);
        run(5);
        chk("t5_req_hold", 32'(sb.mem_req), 32'd1);
        chk("t5_addr_hold", sb.mem_addr, 32'h6001);
        chk("t5_dout_hold", 32'(sb.mem_dout), 32'hF0);
        sb.mem_gnt = 1;
        run(6);
        // load lookup against draining and pending committed stores
        sb.mem_gnt = 0;
        sb.ld_addr = 32'h1000;
        alloc(5'd10, 32'h3000, 32'h11, 2'd0);
        commit(5'd10);
        alloc(5'd11, 32'h1000, 32'h12345678, 2'd2);
        commit(5'd11);
        run(1);
`ifdef SB_FWD_EN
        chk("t6_hit", 32'(sb.ld_hit), 32'd1);
        chk("t6_data", sb.ld_data, 32'h12345678);
        chk("t6_stall", 32'(sb.ld_stall), 32'd0);
`else
        chk("t6_hit", 32'(sb.ld_hit), 32'd0);
        chk("t6_stall", 32'(sb.ld_stall), 32'd1);
`endif
        sb.ld_addr = 32'h3001;
        #1;
        chk("t6_drain_stall", 32'(sb.ld_stall), 32'd1);
        chk("t6_drain_hit", 32'(sb.ld_hit), 32'd0);
        sb.ld_addr = 32'h1004;
        #1;
        chk("t6_miss_stall", 32'(sb.ld_stall), 32'd0);
        sb.rdy_in = 0;
        sb.mem_gnt = 1;
        alloc(5'd12, 32'h8000, 32'h1, 2'd0);
        run(2);
        chk("t6_rdy_req", 32'(sb.mem_req), 32'd0);
        sb.rdy_in = 1;
        run(10);
        chk("t6_store_cnt", sb.store_cnt, 32'd16);
        // reset while writing byte 2 of a word
        alloc(5'd12, 32'h7000, 32'h89ABCDEF, 2'd2);
        commit(5'd12);
        run(3);
        chk("t7_mid_addr", sb.mem_addr, 32'h7002);
        rst_in = 0;
        #1;
        chk("t7_req", 32'(sb.mem_req), 32'd0);
        chk("t7_cnt", sb.store_cnt, 32'd0);
        chk("t7_busy", 32'(sb.mem_busy), 32'd1);
        mreset();
        run(1);
        rst_in = 1;
        clear_log();
        run(4);
        chk("t7_no_writes", 32'(log_a.size()), 32'd0);
        commit(5'd0);
        chk("t7_commit_busy_err", 32'(sb.sb_err), 32'd1);
        run(1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
